// File: rtl/pdn_rail_sequencer.sv
// Power-rail sequencer: brings supply domains up in ascending order and down in reverse,
// gating each step on power-good plus a settle window, with timeout/brown-out fault handling.
module pdn_rail_sequencer #(
  parameter int N_RAILS     = 7,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDX_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_on,
  input  logic [N_RAILS-1:0] pg,
  output logic [N_RAILS-1:0] rail_en,
  output logic               all_good,
  output logic               busy,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_rail
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_RAILS - 1);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_UP    = 3'd1,
    ST_ON    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [N_RAILS-1:0] rail_en_q, rail_en_d;
  logic               all_good_q, all_good_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   fault_rail_q, fault_rail_d;

  logic               at_target_s;
  logic               advance_s;
  logic               timeout_s;
  logic [N_RAILS-1:0] below_s;
  logic [IDX_W:0]     bo_up_s;
  logic [IDX_W:0]     bo_on_s;

  // Returns {found, index} of the lowest zero bit; lowest index wins for fault_rail.
  function automatic logic [IDX_W:0] lowest_low(input logic [N_RAILS-1:0] v);
    logic [IDX_W:0] r;
    r = '0;
    for (int j = N_RAILS - 1; j >= 0; j--) begin
      if (!v[j]) begin
        r = {1'b1, IDX_W'(j)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      timer_q      <= '0;
      settle_q     <= '0;
      rail_en_q    <= '0;
      all_good_q   <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      settle_q     <= settle_d;
      rail_en_q    <= rail_en_d;
      all_good_q   <= all_good_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  // Next-state logic; brown-out is checked before timeout so it owns fault_rail on a tie
  always_comb begin
    at_target_s  = (pg[idx_q] == (state_q == ST_UP));
    advance_s    = at_target_s && (settle_q == SETTLE_LAST);
    timeout_s    = (timer_q == TIMER_LAST) && !advance_s;
    below_s      = (N_RAILS'(1) << idx_q) - N_RAILS'(1);
    bo_up_s      = lowest_low(pg | ~below_s);
    bo_on_s      = lowest_low(pg);

    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = '0;
    settle_d     = '0;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;

    case (state_q)
      ST_OFF: begin
        rail_en_d = '0;
        idx_d     = '0;
        if (req_on) begin
          state_d   = ST_UP;
          rail_en_d = N_RAILS'(1);
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_UP: begin
        timer_d  = timer_q + TMR_W'(1);
        settle_d = at_target_s ? settle_q + SET_W'(1) : '0;
        if (bo_up_s[IDX_W]) begin
          state_d      = ST_FAULT;
          fault_rail_d = bo_up_s[IDX_W-1:0];
          rail_en_d    = '0;
        end else if (timeout_s) begin
          state_d      = ST_FAULT;
          fault_rail_d = idx_q;
          rail_en_d    = '0;
        end else if (!req_on) begin
          state_d          = ST_DOWN;
          rail_en_d[idx_q] = 1'b0;
          timer_d          = '0;
          settle_d         = '0;
        end else if (advance_s) begin
          timer_d  = '0;
          settle_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_ON;
          end else begin
            idx_d                         = idx_q + IDX_W'(1);
            rail_en_d[idx_q + IDX_W'(1)]  = 1'b1;
          end
        end else begin
          state_d = ST_UP;
        end
      end
      ST_ON: begin
        rail_en_d = '1;
        if (bo_on_s[IDX_W]) begin
          state_d      = ST_FAULT;
          fault_rail_d = bo_on_s[IDX_W-1:0];
          rail_en_d    = '0;
        end else if (!req_on) begin
          state_d             = ST_DOWN;
          idx_d               = LAST_IDX;
          rail_en_d[LAST_IDX] = 1'b0;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_DOWN: begin
        timer_d  = timer_q + TMR_W'(1);
        settle_d = at_target_s ? settle_q + SET_W'(1) : '0;
        if (timeout_s) begin
          state_d      = ST_FAULT;
          fault_rail_d = idx_q;
          rail_en_d    = '0;
        end else if (advance_s) begin
          timer_d  = '0;
          settle_d = '0;
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idx_d                        = idx_q - IDX_W'(1);
            rail_en_d[idx_q - IDX_W'(1)] = 1'b0;
          end
        end else begin
          state_d = ST_DOWN;
        end
      end
      ST_FAULT: begin
        rail_en_d = '0;
        if (!req_on) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d   = ST_OFF;
        idx_d     = '0;
        rail_en_d = '0;
      end
    endcase

    all_good_d = (state_d == ST_ON);
    busy_d     = (state_d == ST_UP) || (state_d == ST_DOWN);
    fault_d    = (state_d == ST_FAULT);
  end

  // Outputs come straight from registers
  always_comb begin
    rail_en    = rail_en_q;
    all_good   = all_good_q;
    busy       = busy_q;
    fault      = fault_q;
    fault_rail = fault_rail_q;
  end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Table-driven, scoreboarded bench for pdn_rail_sequencer; pg follows rail_en with
// zero-delay rise and a two-cycle fall, with a per-rail kill mask for faults/glitches.
module tb_pdn_rail_sequencer;

  logic       clk;
  logic       rst;
  logic       req_on;
  logic [6:0] pg;
  logic [6:0] rail_en;
  logic       all_good;
  logic       busy;
  logic       fault;
  logic [2:0] fault_rail;

  logic [6:0] pg_kill;
  logic [6:0] en_d1;
  logic [6:0] en_d2;

  int n_err;
  int n_checks;
  int n_vec;

  typedef struct {
    logic        req;
    logic [6:0]  kill;
    int          cyc;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl[40];
  logic [12:0] exp_q[$];
  string       name_q[$];

  pdn_rail_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_on     (req_on),
    .pg         (pg),
    .rail_en    (rail_en),
    .all_good   (all_good),
    .busy       (busy),
    .fault      (fault),
    .fault_rail (fault_rail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable history used to delay the falling edge of pg by two cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d1 <= 7'h00;
      en_d2 <= 7'h00;
    end else begin
      en_d1 <= rail_en;
      en_d2 <= en_d1;
    end
  end

  assign pg = (rail_en | en_d2) & ~pg_kill;

  task automatic add(input logic r, input logic [6:0] k, input int c, input logic [6:0] en,
                     input logic ag, input logic b, input logic f, input logic [2:0] fr,
                     input string nm);
    tbl[n_vec].req  = r;
    tbl[n_vec].kill = k;
    tbl[n_vec].cyc  = c;
    tbl[n_vec].exp  = {en, ag, b, f, fr};
    tbl[n_vec].name = nm;
    n_vec++;
  endtask

  task automatic check_pop();
    logic [12:0] e;
    logic [12:0] got;
    string       nm;
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    got = {rail_en, all_good, busy, fault, fault_rail};
    n_checks++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got en=%b ag=%b busy=%b fault=%b fr=%0d, expected en=%b ag=%b busy=%b fault=%b fr=%0d",
               nm, got[12:6], got[5], got[4], got[3], got[2:0],
               e[12:6], e[5], e[4], e[3], e[2:0]);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] k, input int c, input logic [12:0] e,
                      input string nm);
    req_on  = r;
    pg_kill = k;
    exp_q.push_back(e);
    name_q.push_back(nm);
    repeat (c) @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    n_vec    = 0;
    rst      = 1'b1;
    req_on   = 1'b0;
    pg_kill  = 7'h00;

    // power-up / power-down with reversal ignored, then abort at rail 0
    add(1'b1, 7'h00,    1, 7'h01, 1'b0, 1'b1, 1'b0, 3'd0, "up_r0");
    add(1'b1, 7'h00,   15, 7'h01, 1'b0, 1'b1, 1'b0, 3'd0, "up_hold_r0");
    add(1'b1, 7'h00,    1, 7'h03, 1'b0, 1'b1, 1'b0, 3'd0, "up_r1");
    add(1'b1, 7'h00,   80, 7'h7f, 1'b0, 1'b1, 1'b0, 3'd0, "up_r6");
    add(1'b1, 7'h00,   15, 7'h7f, 1'b0, 1'b1, 1'b0, 3'd0, "up_settle_r6");
    add(1'b1, 7'h00,    1, 7'h7f, 1'b1, 1'b0, 1'b0, 3'd0, "all_good_113");
    add(1'b1, 7'h00,    5, 7'h7f, 1'b1, 1'b0, 1'b0, 3'd0, "on_hold");
    add(1'b0, 7'h00,    1, 7'h3f, 1'b0, 1'b1, 1'b0, 3'd0, "dn_r6");
    add(1'b0, 7'h00,   17, 7'h3f, 1'b0, 1'b1, 1'b0, 3'd0, "dn_hold_r6");
    add(1'b0, 7'h00,    1, 7'h1f, 1'b0, 1'b1, 1'b0, 3'd0, "dn_r5");
    add(1'b1, 7'h00,   90, 7'h00, 1'b0, 1'b1, 1'b0, 3'd0, "dn_r0_rev_ignored");
    add(1'b1, 7'h00,   17, 7'h00, 1'b0, 1'b1, 1'b0, 3'd0, "dn_settle_r0");
    add(1'b1, 7'h00,    1, 7'h00, 1'b0, 1'b0, 1'b0, 3'd0, "dn_off");
    add(1'b1, 7'h00,    1, 7'h01, 1'b0, 1'b1, 1'b0, 3'd0, "restart_up");
    add(1'b0, 7'h00,    1, 7'h00, 1'b0, 1'b1, 1'b0, 3'd0, "abort_r0");
    add(1'b0, 7'h00,   18, 7'h00, 1'b0, 1'b0, 1'b0, 3'd0, "abort_r0_off");
    // timeout on rail 3
    add(1'b1, 7'h08,   49, 7'h0f, 1'b0, 1'b1, 1'b0, 3'd0, "to_r3_enabled");
    add(1'b1, 7'h08, 1023, 7'h0f, 1'b0, 1'b1, 1'b0, 3'd0, "to_edge_minus1");
    add(1'b1, 7'h08,    1, 7'h00, 1'b0, 1'b0, 1'b1, 3'd3, "to_fault");
    add(1'b1, 7'h00,    4, 7'h00, 1'b0, 1'b0, 1'b1, 3'd3, "fault_sticky");
    add(1'b0, 7'h00,    1, 7'h00, 1'b0, 1'b0, 1'b0, 3'd3, "fault_clear");
    add(1'b0, 7'h00,    3, 7'h00, 1'b0, 1'b0, 1'b0, 3'd3, "off_fr_hold");
    // brown-out in ON
    add(1'b1, 7'h00,  113, 7'h7f, 1'b1, 1'b0, 1'b0, 3'd3, "on_again");
    add(1'b1, 7'h20,    1, 7'h00, 1'b0, 1'b0, 1'b1, 3'd5, "brownout_r5");
    add(1'b1, 7'h00,    2, 7'h00, 1'b0, 1'b0, 1'b1, 3'd5, "bo_sticky");
    add(1'b0, 7'h00,    1, 7'h00, 1'b0, 1'b0, 1'b0, 3'd5, "bo_clear");
    add(1'b0, 7'h00,    3, 7'h00, 1'b0, 1'b0, 1'b0, 3'd5, "off_hold2");
    // abort while rail 4 is settling
    add(1'b1, 7'h00,   66, 7'h1f, 1'b0, 1'b1, 1'b0, 3'd5, "ab_up_r4");
    add(1'b0, 7'h00,    1, 7'h0f, 1'b0, 1'b1, 1'b0, 3'd5, "ab_dn_r4");
    add(1'b0, 7'h00,   18, 7'h07, 1'b0, 1'b1, 1'b0, 3'd5, "ab_dn_r3");
    add(1'b0, 7'h00,   54, 7'h00, 1'b0, 1'b1, 1'b0, 3'd5, "ab_dn_r0");
    add(1'b0, 7'h00,   18, 7'h00, 1'b0, 1'b0, 1'b0, 3'd5, "ab_off");

    // reset state
    @(posedge clk);
    #1;
    exp_q.push_back(13'h0000);
    name_q.push_back("reset_state");
    check_pop();
    rst = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      step(tbl[i].req, tbl[i].kill, tbl[i].cyc, tbl[i].exp, tbl[i].name);
    end

    // pg[2] glitch after 11 settle counts delays rail 3 by glitch length + 11
    step(1'b1, 7'h00, 44, {7'h07, 1'b0, 1'b1, 1'b0, 3'd5}, "gl_pre");
    step(1'b1, 7'h04,  3, {7'h07, 1'b0, 1'b1, 1'b0, 3'd5}, "gl_low_no_fault");
    step(1'b1, 7'h00, 15, {7'h07, 1'b0, 1'b1, 1'b0, 3'd5}, "gl_r3_not_yet");
    step(1'b1, 7'h00,  1, {7'h0f, 1'b0, 1'b1, 1'b0, 3'd5}, "gl_r3_delayed");

    // asynchronous reset mid-UP
    #3;
    rst    = 1'b1;
    req_on = 1'b0;
    exp_q.push_back(13'h0000);
    name_q.push_back("async_reset");
    #1;
    check_pop();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 7'h00,  3, 13'h0000, "post_rst_idle");
    step(1'b1, 7'h00,  1, {7'h01, 1'b0, 1'b1, 1'b0, 3'd0}, "post_rst_r0");
    step(1'b1, 7'h00, 16, {7'h03, 1'b0, 1'b1, 1'b0, 3'd0}, "post_rst_r1");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
